reorder_buffer: RTL and testbench

//  Parametrised in-order-retire reorder buffer for the OoO core, a multi-writeback successor to rob.

---
 rtl/ooo_pkg.sv | 19 +
 rtl/reorder_buffer_wb_arb.sv | 37 +++
 rtl/reorder_buffer.sv | 141 ++++++++++++++
 tb/tb_reorder_buffer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ooo_pkg.sv
// Shared OoO core definitions: default widths and the ROB entry record.
// Imported by reorder_buffer; no ports.
package ooo_pkg;

    localparam int XLEN       = 32;
    localparam int PREG_W     = 5;
    localparam int ROB_DEPTH  = 32;
    localparam int ROB_NUM_WB = 3;

    typedef struct packed {
        logic              valid;
        logic              done;
        logic [PREG_W-1:0] prd;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   inst;
        logic [XLEN-1:0]   value;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_wb_arb.sv
// Writeback arbiter: per ROB entry, resolves NUM_WB result ports into a
// hit bit and a value; on an index collision the lowest port wins.
// Ports:
//   wb_valid_i  per-port result valid
//   wb_idx_i    per-port ROB index, port p at [p*IDX_W +: IDX_W]
//   wb_value_i  per-port result, port p at [p*XLEN +: XLEN]
//   hit_o       entry e is written this cycle
//   value_o     value written to entry e
module reorder_buffer_wb_arb #(
    parameter int DEPTH  = 32,
    parameter int IDX_W  = 5,
    parameter int NUM_WB = 3,
    parameter int XLEN   = 32
) (
    input  logic [NUM_WB-1:0]            wb_valid_i,
    input  logic [NUM_WB*IDX_W-1:0]      wb_idx_i,
    input  logic [NUM_WB*XLEN-1:0]       wb_value_i,
    output logic [DEPTH-1:0]             hit_o,
    output logic [DEPTH-1:0][XLEN-1:0]   value_o
);

    // Scan ports high to low so the lowest-numbered hit is the last assignment.
    always_comb begin
        hit_o   = '0;
        value_o = '0;
        for (int e = 0; e < DEPTH; e++) begin
            for (int p = NUM_WB - 1; p >= 0; p--) begin
                if (wb_valid_i[p] &&
                    wb_idx_i[p*IDX_W +: IDX_W] == IDX_W'(e)) begin
                    hit_o[e]   = 1'b1;
                    value_o[e] = wb_value_i[p*XLEN +: XLEN];
                end
            end
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// In-order-retire reorder buffer with NUM_WB writeback ports.
// Allocates at the tail, marks entries done on writeback, retires the head.
// Optional macro ROB_FLUSH_EN adds flush_i, which empties the buffer.
// Ports:
//   clk_i, reset_i            clock, async active-low reset
//   flush_i                   (ROB_FLUSH_EN only) clear all entries
//   alloc_valid_i/ready_o     dispatch handshake; prd/pc/inst payload
//   alloc_idx_o               index the next allocation receives
//   wb_valid_i/idx_i/value_i  writeback ports
//   commit_ready_i/valid_o    retire handshake; idx/prd/value/pc/inst
//   empty_o, full_o, count_o  occupancy
module reorder_buffer #(
    parameter int DEPTH  = ooo_pkg::ROB_DEPTH,
    parameter int IDX_W  = $clog2(DEPTH),
    parameter int NUM_WB = ooo_pkg::ROB_NUM_WB,
    parameter int XLEN   = ooo_pkg::XLEN,
    parameter int PREG_W = ooo_pkg::PREG_W
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
`ifdef ROB_FLUSH_EN
    input  logic                     flush_i,
`endif
    input  logic                     alloc_valid_i,
    output logic                     alloc_ready_o,
    input  logic [PREG_W-1:0]        alloc_prd_i,
    input  logic [XLEN-1:0]          alloc_pc_i,
    input  logic [XLEN-1:0]          alloc_inst_i,
    output logic [IDX_W-1:0]         alloc_idx_o,
    input  logic [NUM_WB-1:0]        wb_valid_i,
    input  logic [NUM_WB*IDX_W-1:0]  wb_idx_i,
    input  logic [NUM_WB*XLEN-1:0]   wb_value_i,
    input  logic                     commit_ready_i,
    output logic                     commit_valid_o,
    output logic [IDX_W-1:0]         commit_idx_o,
    output logic [PREG_W-1:0]        commit_prd_o,
    output logic [XLEN-1:0]          commit_value_o,
    output logic [XLEN-1:0]          commit_pc_o,
    output logic [XLEN-1:0]          commit_inst_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [IDX_W:0]           count_o
);

    import ooo_pkg::*;

    rob_entry_t rob_q [DEPTH];

    logic [IDX_W:0]   head_q;
    logic [IDX_W:0]   tail_q;
    logic [IDX_W-1:0] head_idx;
    logic [IDX_W-1:0] tail_idx;
    rob_entry_t       head_e;
    logic             flush;
    logic             alloc_fire;
    logic             commit_fire;

    logic [DEPTH-1:0]           wb_hit;
    logic [DEPTH-1:0][XLEN-1:0] wb_val;

`ifdef ROB_FLUSH_EN
    assign flush = flush_i;
`else
    assign flush = 1'b0;
`endif

    assign head_idx = head_q[IDX_W-1:0];
    assign tail_idx = tail_q[IDX_W-1:0];
    assign head_e   = rob_q[head_idx];

    // Wrap bit distinguishes full from empty when the low bits match.
    assign empty_o = (head_q == tail_q);
    assign full_o  = (head_q[IDX_W] != tail_q[IDX_W]) &&
                     (head_idx == tail_idx);
    assign count_o = tail_q - head_q;

    assign alloc_ready_o  = ~full_o & ~flush;
    assign alloc_idx_o    = tail_idx;
    assign commit_valid_o = head_e.valid & head_e.done & ~flush;
    assign commit_idx_o   = head_idx;
    assign commit_prd_o   = head_e.prd;
    assign commit_value_o = head_e.value;
    assign commit_pc_o    = head_e.pc;
    assign commit_inst_o  = head_e.inst;

    assign alloc_fire  = alloc_valid_i & alloc_ready_o;
    assign commit_fire = commit_valid_o & commit_ready_i;

    reorder_buffer_wb_arb #(
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W),
        .NUM_WB (NUM_WB),
        .XLEN   (XLEN)
    ) u_wb_arb (
        .wb_valid_i (wb_valid_i),
        .wb_idx_i   (wb_idx_i),
        .wb_value_i (wb_value_i),
        .hit_o      (wb_hit),
        .value_o    (wb_val)
    );

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            head_q <= '0;
            tail_q <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                rob_q[e] <= '0;
            end
        end else if (flush) begin
            head_q <= '0;
            tail_q <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                rob_q[e].valid <= 1'b0;
                rob_q[e].done  <= 1'b0;
            end
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                // A fresh allocation masks a stale writeback to its slot.
                if (alloc_fire && tail_idx == IDX_W'(e)) begin
                    rob_q[e].valid <= 1'b1;
                    rob_q[e].done  <= 1'b0;
                    rob_q[e].prd   <= alloc_prd_i;
                    rob_q[e].pc    <= alloc_pc_i;
                    rob_q[e].inst  <= alloc_inst_i;
                end else if (wb_hit[e] && rob_q[e].valid) begin
                    rob_q[e].done  <= 1'b1;
                    rob_q[e].value <= wb_val[e];
                end
            end
            if (commit_fire) begin
                rob_q[head_idx].valid <= 1'b0;
                rob_q[head_idx].done  <= 1'b0;
                head_q <= head_q + 1'b1;
            end
            if (alloc_fire) begin
                tail_q <= tail_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: a queue-based model predicts
// occupancy and retire order; a monitor checks every retirement.
module tb_reorder_buffer;

    localparam int DEPTH  = 32;
    localparam int IDX_W  = 5;
    localparam int NUM_WB = 3;
    localparam int XLEN   = 32;
    localparam int PREG_W = 5;

    logic                    clk_i;
    logic                    reset_i;
`ifdef ROB_FLUSH_EN
    logic                    flush_i;
`endif
    logic                    alloc_valid_i;
    logic                    alloc_ready_o;
    logic [PREG_W-1:0]       alloc_prd_i;
    logic [XLEN-1:0]         alloc_pc_i;
    logic [XLEN-1:0]         alloc_inst_i;
    logic [IDX_W-1:0]        alloc_idx_o;
    logic [NUM_WB-1:0]       wb_valid_i;
    logic [NUM_WB*IDX_W-1:0] wb_idx_i;
    logic [NUM_WB*XLEN-1:0]  wb_value_i;
    logic                    commit_ready_i;
    logic                    commit_valid_o;
    logic [IDX_W-1:0]        commit_idx_o;
    logic [PREG_W-1:0]       commit_prd_o;
    logic [XLEN-1:0]         commit_value_o;
    logic [XLEN-1:0]         commit_pc_o;
    logic [XLEN-1:0]         commit_inst_o;
    logic                    empty_o;
    logic                    full_o;
    logic [IDX_W:0]          count_o;

    reorder_buffer dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
`ifdef ROB_FLUSH_EN
        .flush_i        (flush_i),
`endif
        .alloc_valid_i  (alloc_valid_i),
        .alloc_ready_o  (alloc_ready_o),
        .alloc_prd_i    (alloc_prd_i),
        .alloc_pc_i     (alloc_pc_i),
        .alloc_inst_i   (alloc_inst_i),
        .alloc_idx_o    (alloc_idx_o),
        .wb_valid_i     (wb_valid_i),
        .wb_idx_i       (wb_idx_i),
        .wb_value_i     (wb_value_i),
        .commit_ready_i (commit_ready_i),
        .commit_valid_o (commit_valid_o),
        .commit_idx_o   (commit_idx_o),
        .commit_prd_o   (commit_prd_o),
        .commit_value_o (commit_value_o),
        .commit_pc_o    (commit_pc_o),
        .commit_inst_o  (commit_inst_o),
        .empty_o        (empty_o),
        .full_o         (full_o),
        .count_o        (count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        int          idx;
        logic [4:0]  prd;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] value;
        bit          done;
    } ent_t;

    ent_t rob[$];     // in-flight instructions, oldest first
    ent_t exp_q[$];   // expected retirements
    int   tail_n;
    int   checks;
    int   passed;

    task automatic chk(input string name, input longint act,
                       input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One cycle: check pre-edge status, drive inputs, advance the model.
    task automatic step(input bit a_v, input logic [2:0] wv,
                        input logic [14:0] wi, input logic [95:0] wd,
                        input bit cr);
        bit   cf;
        bit   af;
        bit   claimed [int];
        ent_t n;
        int   id;
        @(negedge clk_i);
        chk("count", count_o, rob.size());
        chk("empty", empty_o, rob.size() == 0);
        chk("full", full_o, rob.size() == DEPTH);
        chk("alloc_ready", alloc_ready_o, rob.size() != DEPTH);
        chk("alloc_idx", alloc_idx_o, tail_n % DEPTH);
        chk("commit_valid", commit_valid_o,
            rob.size() > 0 && rob[0].done);
        n.idx   = tail_n % DEPTH;
        n.prd   = 5'($urandom);
        n.pc    = $urandom;
        n.inst  = $urandom;
        n.value = 0;
        n.done  = 0;
        alloc_valid_i  = a_v;
        alloc_prd_i    = n.prd;
        alloc_pc_i     = n.pc;
        alloc_inst_i   = n.inst;
        wb_valid_i     = wv;
        wb_idx_i       = wi;
        wb_value_i     = wd;
        commit_ready_i = cr;
        cf = rob.size() > 0 && rob[0].done && cr;
        af = a_v && rob.size() < DEPTH;
        if (cf) exp_q.push_back(rob[0]);
        for (int p = 0; p < NUM_WB; p++) begin
            if (!wv[p]) continue;
            id = int'(wi[p*5 +: 5]);
            if (claimed.exists(id)) continue;
            claimed[id] = 1;
            foreach (rob[k]) begin
                if (rob[k].idx == id) begin
                    rob[k].done  = 1;
                    rob[k].value = wd[p*32 +: 32];
                end
            end
        end
        if (cf) void'(rob.pop_front());
        if (af) begin
            rob.push_back(n);
            tail_n++;
        end
    endtask

    task automatic idle(input bit cr);
        step(0, 3'b000, 15'd0, 96'd0, cr);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        reset_i        = 1'b0;
        alloc_valid_i  = 1'b0;
        wb_valid_i     = '0;
        commit_ready_i = 1'b0;
`ifdef ROB_FLUSH_EN
        flush_i        = 1'b0;
`endif
        rob.delete();
        exp_q.delete();
        tail_n = 0;
        #3;
        chk("rst_commit_valid", commit_valid_o, 0);
        chk("rst_empty", empty_o, 1);
        chk("rst_full", full_o, 0);
        chk("rst_count", count_o, 0);
        chk("rst_alloc_idx", alloc_idx_o, 0);
        chk("rst_commit_value", commit_value_o, 0);
        @(negedge clk_i);
        reset_i = 1'b1;
    endtask

    // Monitor: every retirement must match the oldest expected entry.
    always begin
        ent_t e;
        @(negedge clk_i);
        #2;
        if (reset_i && commit_valid_o && commit_ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL commit_unexpected: got idx %0d expected none",
                         commit_idx_o);
            end else begin
                e = exp_q.pop_front();
                chk("commit_idx", commit_idx_o, e.idx);
                chk("commit_prd", commit_prd_o, e.prd);
                chk("commit_pc", commit_pc_o, e.pc);
                chk("commit_inst", commit_inst_o, e.inst);
                chk("commit_value", commit_value_o, e.value);
            end
        end
    end

    initial begin
        int k;
        logic [14:0] wi;
        logic [95:0] wd;
        logic [2:0]  wv;
        checks  = 0;
        passed  = 0;
        tail_n  = 0;
        reset_i = 1'b0;
        alloc_prd_i  = '0;
        alloc_pc_i   = '0;
        alloc_inst_i = '0;
        wb_idx_i     = '0;
        wb_value_i   = '0;

        // Fill to full, one extra alloc is dropped, then drain.
        do_reset();
        for (int i = 0; i < 33; i++) step(1, 3'b000, 15'd0, 96'd0, 0);
        @(negedge clk_i);
        chk("t1_full", full_o, 1);
        chk("t1_count", count_o, 32);
        chk("t1_alloc_ready", alloc_ready_o, 0);
        chk("t1_alloc_idx", alloc_idx_o, 0);
        for (int i = 0; i < 32; i++)
            step(0, 3'b001, 15'(i), 96'($urandom), 1);
        repeat (3) idle(1);

        // Out-of-order completion, in-order retire.
        do_reset();
        repeat (3) step(1, 3'b000, 15'd0, 96'd0, 0);
        step(0, 3'b001, 15'd2, 96'h22, 1);
        step(0, 3'b001, 15'd0, 96'h10, 1);
        idle(1);
        idle(1);
        step(0, 3'b001, 15'd1, 96'h11, 1);
        repeat (3) idle(1);

        // Ports 0 and 2 hit index 5 together: port 0 wins.
        do_reset();
        repeat (6) step(1, 3'b000, 15'd0, 96'd0, 0);
        for (int i = 0; i < 5; i++)
            step(0, 3'b010, 15'(i << 5), 96'($urandom) << 32, 1);
        step(0, 3'b101, {5'd5, 5'd0, 5'd5},
             {32'hBBBB, 32'h0, 32'hAAAA}, 1);
        repeat (4) idle(1);

        // Full with head done: commit fires, alloc refused that cycle.
        do_reset();
        repeat (32) step(1, 3'b000, 15'd0, 96'd0, 0);
        step(0, 3'b001, 15'd0, 96'h5A5A, 0);
        step(1, 3'b000, 15'd0, 96'd0, 1);
        step(1, 3'b000, 15'd0, 96'd0, 1);
        idle(0);

        // Random traffic with pointer wrap.
        do_reset();
        for (int c = 0; c < 100; c++) begin
            wv = 3'($urandom);
            for (int p = 0; p < NUM_WB; p++) begin
                if (rob.size() > 0 && $urandom_range(0, 3) != 0)
                    wi[p*5 +: 5] =
                        5'(rob[$urandom_range(0, rob.size() - 1)].idx);
                else
                    wi[p*5 +: 5] = 5'($urandom);
                wd[p*32 +: 32] = $urandom;
            end
            step($urandom_range(0, 3) != 0, wv, wi, wd,
                 $urandom_range(0, 3) != 0);
        end
        for (int n = 0; n < 300 && rob.size() > 0; n++) begin
            k = -1;
            foreach (rob[j]) if (k < 0 && !rob[j].done) k = j;
            if (k >= 0)
                step(0, 3'b001, 15'(rob[k].idx), 96'($urandom), 1);
            else
                idle(1);
        end
        idle(1);
        @(negedge clk_i);
        chk("t5_drained", empty_o, 1);

`ifdef ROB_FLUSH_EN
        // Flush with a retirement pending: nothing retires.
        do_reset();
        repeat (10) step(1, 3'b000, 15'd0, 96'd0, 0);
        step(0, 3'b001, 15'd0, 96'h77, 0);
        @(negedge clk_i);
        flush_i        = 1'b1;
        commit_ready_i = 1'b1;
        alloc_valid_i  = 1'b1;
        wb_valid_i     = '0;
        #1;
        chk("t6_commit_valid", commit_valid_o, 0);
        chk("t6_alloc_ready", alloc_ready_o, 0);
        @(negedge clk_i);
        flush_i        = 1'b0;
        alloc_valid_i  = 1'b0;
        commit_ready_i = 1'b0;
        rob.delete();
        tail_n = 0;
        #1;
        chk("t6_empty", empty_o, 1);
        chk("t6_alloc_idx", alloc_idx_o, 0);
        idle(0);
`endif

        @(negedge clk_i);
        #3;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
